// File: rtl/store_buffer_pkg.sv
// Shared constants and width helpers for the store buffer and its match logic.
package store_buffer_pkg;

    // Byte offset bits dropped to form a word address.
    localparam int WORD_LSB = 2;

    // Number of byte lanes in a data word.
    function automatic int be_width(input int data_w);
        return data_w / 8;
    endfunction

    // Pointer width for a power-of-two FIFO depth.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Who owns the SRAM port this cycle.
    typedef enum logic [1:0] {
        PORT_IDLE  = 2'd0,
        PORT_READ  = 2'd1,
        PORT_DRAIN = 2'd2
    } port_sel_e;

endpackage

// File: rtl/store_buffer_match.sv
// Compares a load against all queued stores plus the incoming store and picks
// the youngest overlapping one.
module store_buffer_match
    import store_buffer_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int WADDR_W = 30,
    parameter int DATA_W  = 32,
    parameter int BE_W    = 4,
    parameter int PTR_W   = 2
) (
    input  logic [DEPTH-1:0]              ent_valid,
    input  logic [DEPTH-1:0][WADDR_W-1:0] ent_waddr,
    input  logic [DEPTH-1:0][DATA_W-1:0]  ent_data,
    input  logic [DEPTH-1:0][BE_W-1:0]    ent_be,
    input  logic [PTR_W-1:0]              head,
    input  logic                          in_valid,
    input  logic [WADDR_W-1:0]            in_waddr,
    input  logic [DATA_W-1:0]             in_data,
    input  logic [BE_W-1:0]               in_be,
    input  logic                          ld_valid,
    input  logic [WADDR_W-1:0]            ld_waddr,
    input  logic [BE_W-1:0]               ld_be,
    output logic                          hit,
    output logic                          covers,
    output logic [DATA_W-1:0]             sel_data
);

    logic [PTR_W-1:0] idx;
    logic [BE_W-1:0]  sel_be;

    // Walk oldest to youngest so later matches override; the incoming store is youngest of all.
    always_comb begin
        hit      = 1'b0;
        sel_be   = '0;
        sel_data = '0;
        idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PTR_W'(k);
            if (ent_valid[idx] && (ent_waddr[idx] == ld_waddr) && ((ent_be[idx] & ld_be) != '0)) begin
                hit      = 1'b1;
                sel_be   = ent_be[idx];
                sel_data = ent_data[idx];
            end
        end
        if (in_valid && (in_waddr == ld_waddr) && ((in_be & ld_be) != '0)) begin
            hit      = 1'b1;
            sel_be   = in_be;
            sel_data = in_data;
        end
        if (!ld_valid) begin
            hit = 1'b0;
        end
        covers = hit && ((ld_be & ~sel_be) == '0);
    end

endmodule

// File: rtl/store_buffer.sv
// Store buffer between MEM and the single-port data SRAM. Stores queue here and
// drain only when no load needs the port; loads forward from or stall on queued stores.
//
// Store handshake: a store transfers on a rising edge where st_valid && st_ready;
// st_ready depends only on registered occupancy, never on this cycle's load.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     st_valid,
    output logic                     st_ready,
    input  logic [ADDR_W-1:0]        st_addr,
    input  logic [DATA_W-1:0]        st_wdata,
    input  logic [DATA_W/8-1:0]      st_be,
    input  logic                     ld_valid,
    input  logic [ADDR_W-1:0]        ld_addr,
    input  logic [DATA_W/8-1:0]      ld_be,
    output logic                     ld_stall,
    output logic                     ld_fwd_hit,
    output logic [DATA_W-1:0]        ld_fwd_data,
    output logic                     sram_en,
    output logic [DATA_W/8-1:0]      sram_we,
    output logic [ADDR_W-1:0]        sram_addr,
    output logic [DATA_W-1:0]        sram_wdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int BE_W    = be_width(DATA_W);
    localparam int PTR_W   = ptr_width(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int WADDR_W = ADDR_W - WORD_LSB;

    logic [PTR_W-1:0]              head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]              count_q, count_d;
    logic [DEPTH-1:0]              ent_valid_q, ent_valid_d;
    logic [DEPTH-1:0][WADDR_W-1:0] ent_waddr_q, ent_waddr_d;
    logic [DEPTH-1:0][DATA_W-1:0]  ent_data_q, ent_data_d;
    logic [DEPTH-1:0][BE_W-1:0]    ent_be_q, ent_be_d;
    logic                          ld_fwd_hit_q, ld_fwd_hit_d;
    logic [DATA_W-1:0]             ld_fwd_data_q, ld_fwd_data_d;

    logic                          st_push;
    logic                          m_hit, m_covers;
    logic [DATA_W-1:0]             m_sel_data;
    port_sel_e                     port_sel;
    logic                          unused_addr_lsbs;

    assign unused_addr_lsbs = ^{st_addr[WORD_LSB-1:0], ld_addr[WORD_LSB-1:0]};

    assign full        = (count_q == CNT_W'(DEPTH));
    assign empty       = (count_q == '0);
    assign count       = count_q;
    assign st_ready    = !full;
    // Zero-byte stores complete the handshake but carry nothing worth writing.
    assign st_push     = st_valid && st_ready && (st_be != '0);
    assign ld_stall    = m_hit && !m_covers;
    assign ld_fwd_hit  = ld_fwd_hit_q;
    assign ld_fwd_data = ld_fwd_data_q;

    store_buffer_match #(
        .DEPTH  (DEPTH),
        .WADDR_W(WADDR_W),
        .DATA_W (DATA_W),
        .BE_W   (BE_W),
        .PTR_W  (PTR_W)
    ) u_match (
        .ent_valid(ent_valid_q),
        .ent_waddr(ent_waddr_q),
        .ent_data (ent_data_q),
        .ent_be   (ent_be_q),
        .head     (head_q),
        .in_valid (st_push),
        .in_waddr (st_addr[ADDR_W-1:WORD_LSB]),
        .in_data  (st_wdata),
        .in_be    (st_be),
        .ld_valid (ld_valid),
        .ld_waddr (ld_addr[ADDR_W-1:WORD_LSB]),
        .ld_be    (ld_be),
        .hit      (m_hit),
        .covers   (m_covers),
        .sel_data (m_sel_data)
    );

    // Port arbitration: a non-stalled load always wins, otherwise drain the head.
    always_comb begin
        port_sel   = PORT_IDLE;
        sram_en    = 1'b0;
        sram_we    = '0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (ld_valid && !ld_stall) begin
            port_sel  = PORT_READ;
            sram_en   = 1'b1;
            sram_addr = ld_addr;
        end else if (!empty) begin
            port_sel   = PORT_DRAIN;
            sram_en    = 1'b1;
            sram_we    = ent_be_q[head_q];
            sram_addr  = {ent_waddr_q[head_q], {WORD_LSB{1'b0}}};
            sram_wdata = ent_data_q[head_q];
        end
    end

    // FIFO push/pop bookkeeping and forward capture.
    always_comb begin
        head_d        = head_q;
        tail_d        = tail_q;
        ent_valid_d   = ent_valid_q;
        ent_waddr_d   = ent_waddr_q;
        ent_data_d    = ent_data_q;
        ent_be_d      = ent_be_q;
        if (st_push) begin
            ent_valid_d[tail_q] = 1'b1;
            ent_waddr_d[tail_q] = st_addr[ADDR_W-1:WORD_LSB];
            ent_data_d[tail_q]  = st_wdata;
            ent_be_d[tail_q]    = st_be;
            tail_d              = tail_q + 1'b1;
        end
        if (port_sel == PORT_DRAIN) begin
            ent_valid_d[head_q] = 1'b0;
            head_d              = head_q + 1'b1;
        end
        count_d       = count_q + CNT_W'(st_push) - CNT_W'(port_sel == PORT_DRAIN);
        ld_fwd_hit_d  = ld_valid && m_hit && m_covers;
        ld_fwd_data_d = ld_fwd_hit_d ? m_sel_data : ld_fwd_data_q;
    end

    // State registers; reset throws away any stores still queued.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            ent_valid_q   <= '0;
            ent_waddr_q   <= '0;
            ent_data_q    <= '0;
            ent_be_q      <= '0;
            ld_fwd_hit_q  <= 1'b0;
            ld_fwd_data_q <= '0;
        end else begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            ent_valid_q   <= ent_valid_d;
            ent_waddr_q   <= ent_waddr_d;
            ent_data_q    <= ent_data_d;
            ent_be_q      <= ent_be_d;
            ld_fwd_hit_q  <= ld_fwd_hit_d;
            ld_fwd_data_q <= ld_fwd_data_d;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: inputs change on the falling edge, outputs are
// checked #1 later, well away from the rising edge.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_wdata;
    logic [3:0]  st_be;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [3:0]  ld_be;
    logic        ld_stall;
    logic        ld_fwd_hit;
    logic [31:0] ld_fwd_data;
    logic        sram_en;
    logic [3:0]  sram_we;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [2:0]  count;
    logic        empty;
    logic        full;

    int checks = 0;
    int errors = 0;

    store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .st_valid   (st_valid),
        .st_ready   (st_ready),
        .st_addr    (st_addr),
        .st_wdata   (st_wdata),
        .st_be      (st_be),
        .ld_valid   (ld_valid),
        .ld_addr    (ld_addr),
        .ld_be      (ld_be),
        .ld_stall   (ld_stall),
        .ld_fwd_hit (ld_fwd_hit),
        .ld_fwd_data(ld_fwd_data),
        .sram_en    (sram_en),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .count      (count),
        .empty      (empty),
        .full       (full)
    );

    // Clock
    always #5 clk = ~clk;

    // Driver tasks
    task automatic set_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        st_valid = 1'b1;
        st_addr  = a;
        st_wdata = d;
        st_be    = be;
    endtask

    task automatic clr_store();
        st_valid = 1'b0;
        st_addr  = '0;
        st_wdata = '0;
        st_be    = '0;
    endtask

    task automatic set_load(input logic [31:0] a, input logic [3:0] be);
        ld_valid = 1'b1;
        ld_addr  = a;
        ld_be    = be;
    endtask

    task automatic clr_load();
        ld_valid = 1'b0;
        ld_addr  = '0;
        ld_be    = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clr_store();
        clr_load();
        repeat (2) @(negedge clk);
        #1;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b want 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL rst_full: got %b want 0", full); end
        checks++; if (st_ready !== 1'b1) begin errors++; $display("FAIL rst_st_ready: got %b want 1", st_ready); end
        checks++; if (ld_stall !== 1'b0) begin errors++; $display("FAIL rst_ld_stall: got %b want 0", ld_stall); end
        checks++; if (sram_en !== 1'b0) begin errors++; $display("FAIL rst_sram_en: got %b want 0", sram_en); end
        checks++; if (sram_we !== 4'h0) begin errors++; $display("FAIL rst_sram_we: got %h want 0", sram_we); end
        checks++; if (sram_addr !== 32'h0) begin errors++; $display("FAIL rst_sram_addr: got %h want 0", sram_addr); end
        checks++; if (sram_wdata !== 32'h0) begin errors++; $display("FAIL rst_sram_wdata: got %h want 0", sram_wdata); end
        checks++; if (ld_fwd_hit !== 1'b0) begin errors++; $display("FAIL rst_fwd_hit: got %b want 0", ld_fwd_hit); end
        checks++; if (ld_fwd_data !== 32'h0) begin errors++; $display("FAIL rst_fwd_data: got %h want 0", ld_fwd_data); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_single_drain();
        @(negedge clk);
        set_store(32'h100, 32'hDEADBEEF, 4'hF);
        #1;
        checks++; if (sram_en !== 1'b0) begin errors++; $display("FAIL sd_accept_en: got %b want 0", sram_en); end
        @(negedge clk);
        clr_store();
        #1;
        checks++; if (sram_en !== 1'b1) begin errors++; $display("FAIL sd_en: got %b want 1", sram_en); end
        checks++; if (sram_we !== 4'hF) begin errors++; $display("FAIL sd_we: got %h want f", sram_we); end
        checks++; if (sram_addr !== 32'h100) begin errors++; $display("FAIL sd_addr: got %h want 100", sram_addr); end
        checks++; if (sram_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sd_wdata: got %h want deadbeef", sram_wdata); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL sd_count: got %0d want 1", count); end
        @(negedge clk);
        #1;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL sd_empty_after: got %b want 1", empty); end
        checks++; if (sram_en !== 1'b0) begin errors++; $display("FAIL sd_idle_en: got %b want 0", sram_en); end
    endtask

    task automatic test_fill_full();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            set_store(32'h10 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'hF);
            set_load(32'h1000, 4'hF);
            #1;
            checks++; if (sram_we !== 4'h0 || sram_en !== 1'b1) begin errors++; $display("FAIL fill_read%0d: got en=%b we=%h want en=1 we=0", i, sram_en, sram_we); end
            checks++; if (st_ready !== 1'b1) begin errors++; $display("FAIL fill_ready%0d: got %b want 1", i, st_ready); end
        end
        // Fourth store landed: buffer full. Offer one more store that must be refused.
        @(negedge clk);
        set_store(32'h50, 32'h0000_0005, 4'hF);
        #1;
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_flag: got %b want 1", full); end
        checks++; if (st_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", st_ready); end
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d want 4", count); end
        checks++; if (sram_we !== 4'h0) begin errors++; $display("FAIL full_no_write: got %h want 0", sram_we); end
        @(negedge clk);
        clr_store();
        clr_load();
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (sram_we !== 4'hF) begin errors++; $display("FAIL drain%0d_we: got %h want f", i, sram_we); end
            checks++; if (sram_addr !== 32'h10 + 32'(4 * i)) begin errors++; $display("FAIL drain%0d_addr: got %h want %h", i, sram_addr, 32'h10 + 32'(4 * i)); end
            checks++; if (sram_wdata !== 32'hA000_0000 + 32'(i)) begin errors++; $display("FAIL drain%0d_wdata: got %h want %h", i, sram_wdata, 32'hA000_0000 + 32'(i)); end
            checks++; if (count !== 3'(4 - i)) begin errors++; $display("FAIL drain%0d_count: got %0d want %0d", i, count, 4 - i); end
            @(negedge clk);
            #1;
        end
        checks++; if (count !== 3'd0 || empty !== 1'b1) begin errors++; $display("FAIL drain_done: got count=%0d empty=%b want 0/1", count, empty); end
    endtask

    task automatic test_forward();
        @(negedge clk);
        set_store(32'h200, 32'h11223344, 4'hF);
        @(negedge clk);
        clr_store();
        set_load(32'h200, 4'hF);
        #1;
        checks++; if (ld_stall !== 1'b0) begin errors++; $display("FAIL fwd_stall: got %b want 0", ld_stall); end
        checks++; if (sram_en !== 1'b1 || sram_we !== 4'h0) begin errors++; $display("FAIL fwd_read: got en=%b we=%h want en=1 we=0", sram_en, sram_we); end
        checks++; if (sram_addr !== 32'h200) begin errors++; $display("FAIL fwd_read_addr: got %h want 200", sram_addr); end
        @(negedge clk);
        clr_load();
        #1;
        checks++; if (ld_fwd_hit !== 1'b1) begin errors++; $display("FAIL fwd_hit: got %b want 1", ld_fwd_hit); end
        checks++; if (ld_fwd_data !== 32'h11223344) begin errors++; $display("FAIL fwd_data: got %h want 11223344", ld_fwd_data); end
        checks++; if (sram_we !== 4'hF) begin errors++; $display("FAIL fwd_drain_we: got %h want f", sram_we); end
        @(negedge clk);
        #1;
        checks++; if (ld_fwd_hit !== 1'b0) begin errors++; $display("FAIL fwd_hit_clear: got %b want 0", ld_fwd_hit); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fwd_empty: got %b want 1", empty); end
    endtask

    task automatic test_partial_stall();
        @(negedge clk);
        set_store(32'h300, 32'h0000_00AB, 4'h1);
        // Same word but disjoint bytes: no overlap, plain read.
        @(negedge clk);
        clr_store();
        set_load(32'h300, 4'h2);
        #1;
        checks++; if (ld_stall !== 1'b0) begin errors++; $display("FAIL ps_disjoint_stall: got %b want 0", ld_stall); end
        checks++; if (sram_we !== 4'h0 || sram_en !== 1'b1) begin errors++; $display("FAIL ps_disjoint_read: got en=%b we=%h want en=1 we=0", sram_en, sram_we); end
        @(negedge clk);
        set_load(32'h300, 4'hF);
        #1;
        checks++; if (ld_fwd_hit !== 1'b0) begin errors++; $display("FAIL ps_disjoint_fwd: got %b want 0", ld_fwd_hit); end
        checks++; if (ld_stall !== 1'b1) begin errors++; $display("FAIL ps_stall: got %b want 1", ld_stall); end
        checks++; if (sram_we !== 4'h1 || sram_addr !== 32'h300) begin errors++; $display("FAIL ps_drain: got we=%h addr=%h want we=1 addr=300", sram_we, sram_addr); end
        @(negedge clk);
        #1;
        checks++; if (ld_stall !== 1'b0) begin errors++; $display("FAIL ps_release: got %b want 0", ld_stall); end
        checks++; if (sram_we !== 4'h0 || sram_addr !== 32'h300 || sram_en !== 1'b1) begin errors++; $display("FAIL ps_read: got en=%b we=%h addr=%h want en=1 we=0 addr=300", sram_en, sram_we, sram_addr); end
        checks++; if (ld_fwd_hit !== 1'b0) begin errors++; $display("FAIL ps_stalled_fwd: got %b want 0", ld_fwd_hit); end
        @(negedge clk);
        clr_load();
        #1;
        checks++; if (ld_fwd_hit !== 1'b0) begin errors++; $display("FAIL ps_read_fwd: got %b want 0", ld_fwd_hit); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ps_empty: got %b want 1", empty); end
    endtask

    task automatic test_youngest();
        @(negedge clk);
        set_store(32'h400, 32'hAAAAAAAA, 4'hF);
        set_load(32'h2000, 4'hF);
        @(negedge clk);
        set_store(32'h400, 32'hBBBBBBBB, 4'hF);
        @(negedge clk);
        clr_store();
        set_load(32'h400, 4'hF);
        #1;
        checks++; if (ld_stall !== 1'b0 || sram_we !== 4'h0) begin errors++; $display("FAIL yg_q_read: got stall=%b we=%h want 0/0", ld_stall, sram_we); end
        @(negedge clk);
        set_store(32'h400, 32'hCCCCCCCC, 4'hF);
        #1;
        checks++; if (ld_fwd_hit !== 1'b1 || ld_fwd_data !== 32'hBBBBBBBB) begin errors++; $display("FAIL yg_queued: got hit=%b data=%h want 1/bbbbbbbb", ld_fwd_hit, ld_fwd_data); end
        checks++; if (ld_stall !== 1'b0) begin errors++; $display("FAIL yg_in_stall: got %b want 0", ld_stall); end
        @(negedge clk);
        clr_store();
        clr_load();
        #1;
        checks++; if (ld_fwd_hit !== 1'b1 || ld_fwd_data !== 32'hCCCCCCCC) begin errors++; $display("FAIL yg_incoming: got hit=%b data=%h want 1/cccccccc", ld_fwd_hit, ld_fwd_data); end
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL yg_count: got %0d want 3", count); end
        checks++; if (sram_wdata !== 32'hAAAAAAAA) begin errors++; $display("FAIL yg_drain_order: got %h want aaaaaaaa", sram_wdata); end
        repeat (3) @(negedge clk);
        #1;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL yg_empty: got %b want 1", empty); end
    endtask

    task automatic test_reset_mid_drain();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            set_store(32'h600 + 32'(4 * i), 32'h6000 + 32'(i), 4'hF);
            set_load(32'h2000, 4'hF);
        end
        @(negedge clk);
        clr_store();
        clr_load();
        #1;
        checks++; if (count !== 3'd3 || sram_we !== 4'hF) begin errors++; $display("FAIL rmd_pre: got count=%0d we=%h want 3/f", count, sram_we); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL rmd_count: got %0d want 0", count); end
        checks++; if (sram_en !== 1'b0) begin errors++; $display("FAIL rmd_en: got %b want 0", sram_en); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rmd_empty: got %b want 1", empty); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        set_store(32'h700, 32'h55667788, 4'h3);
        #1;
        checks++; if (sram_en !== 1'b0) begin errors++; $display("FAIL rmd_new_accept: got %b want 0", sram_en); end
        @(negedge clk);
        clr_store();
        #1;
        checks++; if (sram_we !== 4'h3 || sram_addr !== 32'h700) begin errors++; $display("FAIL rmd_new_drain: got we=%h addr=%h want 3/700", sram_we, sram_addr); end
        checks++; if (sram_wdata !== 32'h55667788) begin errors++; $display("FAIL rmd_new_wdata: got %h want 55667788", sram_wdata); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL rmd_new_count: got %0d want 1", count); end
        @(negedge clk);
        #1;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rmd_new_empty: got %b want 1", empty); end
    endtask

    // Sequencer and final report
    initial begin
        test_reset();
        test_single_drain();
        test_fill_full();
        test_forward();
        test_partial_stall();
        test_youngest();
        test_reset_mid_drain();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
